dm_arbiter: RTL and testbench

Two-requester arbiter for the single data-memory port, shared between the CPU memory-access stage and a DMA/debug loader. It serialises accesses, drives the DM enable/read/write/address/data pins, waits a fixed memory latency, and returns read data with a one-cycle acknowledge. The CPU has priority, but a starvation counter bounds how long the DMA requester can wait.

---
 rtl/dm_arbiter_if.sv | 51 +++++
 rtl/dm_arbiter.sv | 166 ++++++++++++++++
 tb/tb_dm_arbiter.sv | 392 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dm_arbiter_if.sv
// Bundle of the two requester ports and the data-memory pins served by dm_arbiter.
// The arbiter connects through the slave modport; requesters and the memory
// model connect through the master modport.
interface dm_arbiter_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
);
  // CPU requester
  logic                  cpu_req;
  logic                  cpu_write;
  logic [ADDR_WIDTH-1:0] cpu_addr;
  logic [DATA_WIDTH-1:0] cpu_wdata;
  logic                  cpu_ack;
  logic [DATA_WIDTH-1:0] cpu_rdata;

  // DMA / debug loader requester
  logic                  dma_req;
  logic                  dma_write;
  logic [ADDR_WIDTH-1:0] dma_addr;
  logic [DATA_WIDTH-1:0] dma_wdata;
  logic                  dma_ack;
  logic [DATA_WIDTH-1:0] dma_rdata;

  // Data-memory pins and status
  logic                  dm_enable;
  logic                  dm_read;
  logic                  dm_write;
  logic [ADDR_WIDTH-1:0] dm_address;
  logic [DATA_WIDTH-1:0] dm_in;
  logic [DATA_WIDTH-1:0] dm_out;
  logic                  busy;
  logic                  owner;

  modport slave (
    input  cpu_req, cpu_write, cpu_addr, cpu_wdata,
    input  dma_req, dma_write, dma_addr, dma_wdata,
    input  dm_out,
    output cpu_ack, cpu_rdata, dma_ack, dma_rdata,
    output dm_enable, dm_read, dm_write, dm_address, dm_in,
    output busy, owner
  );

  modport master (
    output cpu_req, cpu_write, cpu_addr, cpu_wdata,
    output dma_req, dma_write, dma_addr, dma_wdata,
    output dm_out,
    input  cpu_ack, cpu_rdata, dma_ack, dma_rdata,
    input  dm_enable, dm_read, dm_write, dm_address, dm_in,
    input  busy, owner
  );
endinterface

// File: rtl/dm_arbiter.sv
// Two-requester arbiter for the single data-memory port. The CPU has priority,
// a starvation counter forces a DMA grant after STARVE_LIMIT consecutive CPU
// grants with DMA waiting. Each access holds dm_enable for MEM_LATENCY cycles,
// then returns a one-cycle ack (with read data) to the owner.
module dm_arbiter #(
  parameter int ADDR_WIDTH   = 12,
  parameter int DATA_WIDTH   = 32,
  parameter int MEM_LATENCY  = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic clock,
  input  logic reset,
  dm_arbiter_if.slave bus
);

  localparam int LAT_W    = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [LAT_W-1:0]      lat_cnt_q, lat_cnt_d;
  logic [STARVE_W-1:0]   starve_cnt_q, starve_cnt_d;
  logic                  owner_q, owner_d;
  logic                  busy_q, busy_d;
  logic                  dm_enable_q, dm_enable_d;
  logic                  dm_read_q, dm_read_d;
  logic                  dm_write_q, dm_write_d;
  logic [ADDR_WIDTH-1:0] dm_address_q, dm_address_d;
  logic [DATA_WIDTH-1:0] dm_in_q, dm_in_d;
  logic                  cpu_ack_q, cpu_ack_d;
  logic                  dma_ack_q, dma_ack_d;
  logic [DATA_WIDTH-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_WIDTH-1:0] dma_rdata_q, dma_rdata_d;

  // Arbitration helpers, meaningful only in IDLE with a request present.
  logic                  grant_dma;
  logic                  win_write;
  logic                  starved;

  // Next-state, grant decision and registered-output values.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; a missing default here would infer a latch.
    state_d      = state_q;
    lat_cnt_d    = lat_cnt_q;
    starve_cnt_d = starve_cnt_q;
    owner_d      = owner_q;
    busy_d       = busy_q;
    dm_enable_d  = dm_enable_q;
    dm_read_d    = dm_read_q;
    dm_write_d   = dm_write_q;
    dm_address_d = dm_address_q;
    dm_in_d      = dm_in_q;
    cpu_ack_d    = 1'b0;
    dma_ack_d    = 1'b0;
    cpu_rdata_d  = cpu_rdata_q;
    dma_rdata_d  = dma_rdata_q;
    starved      = (starve_cnt_q == STARVE_W'(STARVE_LIMIT));
    grant_dma    = bus.dma_req && (!bus.cpu_req || starved);
    win_write    = grant_dma ? bus.dma_write : bus.cpu_write;

    unique case (state_q)
      IDLE: begin
        if (bus.cpu_req || bus.dma_req) begin
          owner_d      = grant_dma;
          dm_address_d = grant_dma ? bus.dma_addr  : bus.cpu_addr;
          dm_in_d      = grant_dma ? bus.dma_wdata : bus.cpu_wdata;
          dm_enable_d  = 1'b1;
          dm_read_d    = !win_write;
          dm_write_d   = win_write;
          lat_cnt_d    = LAT_W'(MEM_LATENCY - 1);
          busy_d       = 1'b1;
          state_d      = ACCESS;
          // Count only CPU wins that made a waiting DMA requester wait longer.
          if (grant_dma || !bus.dma_req) begin
            starve_cnt_d = '0;
          end else if (!starved) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
          end
        end
      end

      ACCESS: begin
        if (lat_cnt_q == '0) begin
          if (dm_read_q) begin
            if (owner_q) dma_rdata_d = bus.dm_out;
            else         cpu_rdata_d = bus.dm_out;
          end
          dm_enable_d = 1'b0;
          dm_read_d   = 1'b0;
          dm_write_d  = 1'b0;
          cpu_ack_d   = !owner_q;
          dma_ack_d   = owner_q;
          state_d     = DONE;
        end else begin
          lat_cnt_d = lat_cnt_q - 1'b1;
        end
      end

      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end

      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any in-flight access.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      lat_cnt_q    <= '0;
      starve_cnt_q <= '0;
      owner_q      <= 1'b0;
      busy_q       <= 1'b0;
      dm_enable_q  <= 1'b0;
      dm_read_q    <= 1'b0;
      dm_write_q   <= 1'b0;
      dm_address_q <= '0;
      dm_in_q      <= '0;
      cpu_ack_q    <= 1'b0;
      dma_ack_q    <= 1'b0;
      cpu_rdata_q  <= '0;
      dma_rdata_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register updates from the
      // values present before this edge, independent of statement order.
      state_q      <= state_d;
      lat_cnt_q    <= lat_cnt_d;
      starve_cnt_q <= starve_cnt_d;
      owner_q      <= owner_d;
      busy_q       <= busy_d;
      dm_enable_q  <= dm_enable_d;
      dm_read_q    <= dm_read_d;
      dm_write_q   <= dm_write_d;
      dm_address_q <= dm_address_d;
      dm_in_q      <= dm_in_d;
      cpu_ack_q    <= cpu_ack_d;
      dma_ack_q    <= dma_ack_d;
      cpu_rdata_q  <= cpu_rdata_d;
      dma_rdata_q  <= dma_rdata_d;
    end
  end

  assign bus.cpu_ack    = cpu_ack_q;
  assign bus.cpu_rdata  = cpu_rdata_q;
  assign bus.dma_ack    = dma_ack_q;
  assign bus.dma_rdata  = dma_rdata_q;
  assign bus.dm_enable  = dm_enable_q;
  assign bus.dm_read    = dm_read_q;
  assign bus.dm_write   = dm_write_q;
  assign bus.dm_address = dm_address_q;
  assign bus.dm_in      = dm_in_q;
  assign bus.busy       = busy_q;
  assign bus.owner      = owner_q;

endmodule

// File: tb/tb_dm_arbiter.sv
// Testbench for dm_arbiter: two instances (memory latency 1 and 3) driven from
// a per-cycle vector table, hand-written corner sequences and random
// requesters, checked against a transaction-timing reference model.
module tb_dm_arbiter;
  localparam int AW  = 12;
  localparam int DW  = 32;
  localparam int SL  = 4;
  localparam int ML0 = 1;
  localparam int ML1 = 3;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  typedef struct packed {
    logic          creq;
    logic          cwr;
    logic [AW-1:0] caddr;
    logic [DW-1:0] cwd;
    logic          dreq;
    logic          dwr;
    logic [AW-1:0] daddr;
    logic [DW-1:0] dwd;
    logic [DW-1:0] dout;
  } stim_t;

  typedef struct packed {
    logic          en;
    logic          rd;
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] din;
    logic          cack;
    logic          dack;
    logic [DW-1:0] crd;
    logic [DW-1:0] drd;
    logic          busy;
    logic          owner;
  } obs_t;

  typedef struct packed {
    stim_t s;
    obs_t  e;
  } vec_t;

  // Reference model: one record per instance, in terms of the grant cycle.
  typedef struct {
    int            g;        // first ACCESS cycle of the latest grant
    int            free_at;  // first IDLE cycle after the latest grant
    int            starve;
    logic          owner;
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] din;
    logic [DW-1:0] crd;
    logic [DW-1:0] drd;
  } mdl_t;

  stim_t stim [2];
  obs_t  obs  [2];
  mdl_t  m    [2];
  int    cyc;
  int    n_vec = 0;
  int    n_bad = 0;

  dm_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus0 ();
  dm_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus1 ();

  dm_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_LATENCY(ML0), .STARVE_LIMIT(SL))
    dut0 (.clock(clock), .reset(reset), .bus(bus0));
  dm_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_LATENCY(ML1), .STARVE_LIMIT(SL))
    dut1 (.clock(clock), .reset(reset), .bus(bus1));

  assign bus0.cpu_req   = stim[0].creq;
  assign bus0.cpu_write = stim[0].cwr;
  assign bus0.cpu_addr  = stim[0].caddr;
  assign bus0.cpu_wdata = stim[0].cwd;
  assign bus0.dma_req   = stim[0].dreq;
  assign bus0.dma_write = stim[0].dwr;
  assign bus0.dma_addr  = stim[0].daddr;
  assign bus0.dma_wdata = stim[0].dwd;
  assign bus0.dm_out    = stim[0].dout;
  assign bus1.cpu_req   = stim[1].creq;
  assign bus1.cpu_write = stim[1].cwr;
  assign bus1.cpu_addr  = stim[1].caddr;
  assign bus1.cpu_wdata = stim[1].cwd;
  assign bus1.dma_req   = stim[1].dreq;
  assign bus1.dma_write = stim[1].dwr;
  assign bus1.dma_addr  = stim[1].daddr;
  assign bus1.dma_wdata = stim[1].dwd;
  assign bus1.dm_out    = stim[1].dout;

  assign obs[0] = {bus0.dm_enable, bus0.dm_read, bus0.dm_write, bus0.dm_address, bus0.dm_in,
                   bus0.cpu_ack, bus0.dma_ack, bus0.cpu_rdata, bus0.dma_rdata, bus0.busy, bus0.owner};
  assign obs[1] = {bus1.dm_enable, bus1.dm_read, bus1.dm_write, bus1.dm_address, bus1.dm_in,
                   bus1.cpu_ack, bus1.dma_ack, bus1.cpu_rdata, bus1.dma_rdata, bus1.busy, bus1.owner};

  function automatic int ml(input int d);
    return (d == 0) ? ML0 : ML1;
  endfunction

  function automatic void model_reset(input int d);
    m[d].g       = -1000;
    m[d].free_at = 0;
    m[d].starve  = 0;
    m[d].owner   = 1'b0;
    m[d].wr      = 1'b0;
    m[d].addr    = '0;
    m[d].din     = '0;
    m[d].crd     = '0;
    m[d].drd     = '0;
  endfunction

  // Apply the rules at the edge that ends cycle 'cyc'.
  function automatic void model_edge(input int d);
    int   c;
    logic dwin;
    c = cyc;
    if (c == m[d].g + ml(d) - 1 && !m[d].wr) begin
      if (m[d].owner) m[d].drd = stim[d].dout;
      else            m[d].crd = stim[d].dout;
    end
    if (c >= m[d].free_at && (stim[d].creq || stim[d].dreq)) begin
      dwin = stim[d].dreq && (!stim[d].creq || m[d].starve == SL);
      if (dwin || !stim[d].dreq) m[d].starve = 0;
      else if (m[d].starve < SL) m[d].starve = m[d].starve + 1;
      m[d].owner   = dwin;
      m[d].wr      = dwin ? stim[d].dwr   : stim[d].cwr;
      m[d].addr    = dwin ? stim[d].daddr : stim[d].caddr;
      m[d].din     = dwin ? stim[d].dwd   : stim[d].cwd;
      m[d].g       = c + 1;
      m[d].free_at = c + ml(d) + 2;
    end
  endfunction

  function automatic obs_t model_out(input int d);
    obs_t r;
    int   x;
    int   g;
    int   lat;
    logic act;
    x   = cyc;
    g   = m[d].g;
    lat = ml(d);
    act = (x >= g) && (x <= g + lat - 1);
    r.en    = act;
    r.rd    = act && !m[d].wr;
    r.wr    = act && m[d].wr;
    r.addr  = m[d].addr;
    r.din   = m[d].din;
    r.cack  = (x == g + lat) && !m[d].owner;
    r.dack  = (x == g + lat) && m[d].owner;
    r.crd   = m[d].crd;
    r.drd   = m[d].drd;
    r.busy  = (x >= g) && (x <= g + lat);
    r.owner = m[d].owner;
    return r;
  endfunction

  function automatic stim_t st(input logic creq, input logic cwr, input logic [AW-1:0] caddr,
                               input logic [DW-1:0] cwd, input logic dreq, input logic dwr,
                               input logic [AW-1:0] daddr, input logic [DW-1:0] dwd,
                               input logic [DW-1:0] dout);
    stim_t s;
    s = {creq, cwr, caddr, cwd, dreq, dwr, daddr, dwd, dout};
    return s;
  endfunction

  function automatic obs_t ex(input logic en, input logic rd, input logic wr,
                              input logic [AW-1:0] addr, input logic [DW-1:0] din,
                              input logic cack, input logic dack, input logic [DW-1:0] crd,
                              input logic [DW-1:0] drd, input logic busy, input logic owner);
    obs_t o;
    o = {en, rd, wr, addr, din, cack, dack, crd, drd, busy, owner};
    return o;
  endfunction

  function automatic vec_t mkv(input stim_t s, input obs_t e);
    vec_t v;
    v.s = s;
    v.e = e;
    return v;
  endfunction

  task automatic compare(input int d, input obs_t exp, input string name);
    n_vec++;
    if (obs[d] !== exp) begin
      n_bad++;
      $display("FAIL %s dut%0d cyc=%0d got=%h expected=%h", name, d, cyc, obs[d], exp);
    end
  endtask

  task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    if (!reset) begin
      model_edge(0);
      model_edge(1);
    end
    cyc++;
    #1;
  endtask

  task automatic tick_check(input string name);
    tick();
    compare(0, model_out(0), name);
    compare(1, model_out(1), name);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [$];
    int   seq [$];
    int   acks [$];
    int   cack_seen;
    int   k;

    cyc = 0;
    for (int d = 0; d < 2; d++) begin
      stim[d] = '0;
      model_reset(d);
    end

    // Reset state
    tick_check("reset_hold");
    tick_check("reset_hold");
    compare(0, '0, "reset_zero");
    compare(1, '0, "reset_zero");
    reset = 1'b0;
    tick_check("after_release");

    // Single CPU read, then CPU write racing a DMA read (latency 1 instance)
    tbl.push_back(mkv(st(1, 0, 'h010, 0, 0, 0, 0, 0, 'hDEADBEEF),
                      ex(1, 1, 0, 'h010, 0, 0, 0, 0, 0, 1, 0)));
    tbl.push_back(mkv(st(1, 0, 'h010, 0, 0, 0, 0, 0, 'hDEADBEEF),
                      ex(0, 0, 0, 'h010, 0, 1, 0, 'hDEADBEEF, 0, 1, 0)));
    tbl.push_back(mkv(st(0, 0, 0, 0, 0, 0, 0, 0, 0),
                      ex(0, 0, 0, 'h010, 0, 0, 0, 'hDEADBEEF, 0, 0, 0)));
    tbl.push_back(mkv(st(1, 1, 'h004, 'h12345678, 1, 0, 'h008, 0, 0),
                      ex(1, 0, 1, 'h004, 'h12345678, 0, 0, 'hDEADBEEF, 0, 1, 0)));
    tbl.push_back(mkv(st(1, 1, 'h004, 'h12345678, 1, 0, 'h008, 0, 0),
                      ex(0, 0, 0, 'h004, 'h12345678, 1, 0, 'hDEADBEEF, 0, 1, 0)));
    tbl.push_back(mkv(st(0, 1, 'h004, 'h12345678, 1, 0, 'h008, 0, 0),
                      ex(0, 0, 0, 'h004, 'h12345678, 0, 0, 'hDEADBEEF, 0, 0, 0)));
    tbl.push_back(mkv(st(0, 0, 0, 0, 1, 0, 'h008, 0, 'hCAFEF00D),
                      ex(1, 1, 0, 'h008, 0, 0, 0, 'hDEADBEEF, 0, 1, 1)));
    tbl.push_back(mkv(st(0, 0, 0, 0, 1, 0, 'h008, 0, 'hCAFEF00D),
                      ex(0, 0, 0, 'h008, 0, 0, 1, 'hDEADBEEF, 'hCAFEF00D, 1, 1)));
    tbl.push_back(mkv(st(0, 0, 0, 0, 0, 0, 0, 0, 0),
                      ex(0, 0, 0, 'h008, 0, 0, 0, 'hDEADBEEF, 'hCAFEF00D, 0, 1)));
    for (int i = 0; i < tbl.size(); i++) begin
      stim[0] = tbl[i].s;
      tick();
      compare(0, tbl[i].e, $sformatf("table_row%0d", i));
      compare(1, model_out(1), $sformatf("table_idle%0d", i));
    end

    // Starvation: both requesters held, grant order C,C,C,C,D repeating
    stim[0] = st(1, 0, 'h100, 0, 1, 0, 'h200, 0, 'h5A5A5A5A);
    for (int i = 0; i < 60 && seq.size() < 10; i++) begin
      tick_check("starve_model");
      if (obs[0].cack) seq.push_back(0);
      if (obs[0].dack) seq.push_back(1);
    end
    check_val("starve_ack_count", seq.size(), 10);
    for (int i = 0; i < seq.size() && i < 10; i++)
      check_val($sformatf("starve_order%0d", i), seq[i], (i % 5 == 4) ? 1 : 0);
    stim[0] = '0;
    tick_check("starve_drain");

    // Back-to-back DMA writes: 3-cycle ack cadence, rdata untouched
    k = 0;
    cack_seen = 0;
    stim[0] = st(0, 0, 0, 0, 1, 1, 'h300, 'hA000, 'h0BADF00D);
    for (int i = 0; i < 30 && k < 3; i++) begin
      tick_check("dmawr_model");
      if (obs[0].cack) cack_seen++;
      if (obs[0].dack) begin
        acks.push_back(cyc);
        k++;
        stim[0].daddr = AW'('h300 + k);
        stim[0].dwd   = 'hA000 + k;
        if (k == 3) stim[0].dreq = 1'b0;
      end
    end
    check_val("dmawr_ack_count", acks.size(), 3);
    if (acks.size() == 3) begin
      check_val("dmawr_cadence1", acks[1] - acks[0], 3);
      check_val("dmawr_cadence2", acks[2] - acks[1], 3);
    end
    check_val("dmawr_rdata_kept", obs[0].drd, 'h5A5A5A5A);
    check_val("dmawr_no_cpu_ack", cack_seen, 0);
    tick_check("dmawr_drain");

    // Latency 3: enable for three cycles, dm_out taken only in the third
    stim[1] = st(0, 0, 0, 0, 1, 0, 'h0AB, 0, 0);
    tick_check("lat3_grant");
    check_val("lat3_en1", obs[1].en, 1);
    stim[1].dout = 'h111;
    tick_check("lat3_a2");
    check_val("lat3_en2", obs[1].en, 1);
    stim[1].dout = 'h222;
    tick_check("lat3_a3");
    check_val("lat3_en3", {obs[1].en, obs[1].dack}, 2'b10);
    stim[1].dout = 'h333;
    tick_check("lat3_done");
    check_val("lat3_ack", {obs[1].en, obs[1].dack}, 2'b01);
    check_val("lat3_rdata", obs[1].drd, 'h333);
    stim[1] = '0;
    tick_check("lat3_idle");
    check_val("lat3_idle_busy", obs[1].busy, 0);

    // Reset during the first ACCESS cycle of a CPU read
    stim[0] = st(1, 0, 'h055, 0, 0, 0, 0, 0, 'h77);
    tick_check("rst_grant");
    #2;
    reset = 1'b1;
    model_reset(0);
    model_reset(1);
    #1;
    compare(0, '0, "rst_async_zero");
    compare(1, '0, "rst_async_zero");
    stim[0] = '0;
    tick_check("rst_hold");
    reset = 1'b0;
    tick_check("rst_no_ack");
    check_val("rst_no_cack", obs[0].cack, 0);
    stim[0] = st(1, 0, 'h066, 0, 0, 0, 0, 0, 'h99);
    tick_check("rst_new_access");
    tick_check("rst_new_done");
    check_val("rst_new_cack", obs[0].cack, 1);
    check_val("rst_new_rdata", obs[0].crd, 'h99);
    stim[0] = '0;
    tick_check("rst_new_idle");

    // Random requesters on both instances
    for (int t = 0; t < 2500; t++) begin
      for (int d = 0; d < 2; d++) begin
        stim[d].dout = $urandom;
        if (obs[d].cack) begin
          stim[d].creq = 1'b0;
        end else if (!stim[d].creq) begin
          if ($urandom_range(0, 2) == 0) begin
            stim[d].creq  = 1'b1;
            stim[d].cwr   = 1'($urandom);
            stim[d].caddr = AW'($urandom);
            stim[d].cwd   = $urandom;
          end
        end else if ($urandom_range(0, 3) == 0) begin
          stim[d].cwr   = 1'($urandom);
          stim[d].caddr = AW'($urandom);
          stim[d].cwd   = $urandom;
        end
        if (obs[d].dack) begin
          stim[d].dreq = 1'b0;
        end else if (!stim[d].dreq) begin
          if ($urandom_range(0, 2) == 0) begin
            stim[d].dreq  = 1'b1;
            stim[d].dwr   = 1'($urandom);
            stim[d].daddr = AW'($urandom);
            stim[d].dwd   = $urandom;
          end
        end else if ($urandom_range(0, 3) == 0) begin
          stim[d].dwr   = 1'($urandom);
          stim[d].daddr = AW'($urandom);
          stim[d].dwd   = $urandom;
        end
      end
      tick_check("random");
    end

    stim[0] = '0;
    stim[1] = '0;
    for (int i = 0; i < 6; i++) tick_check("final_drain");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
